// File: rtl/packet_uart_tx_pkg.sv
// Shared types and constants for the game-state packet UART serializer.
package packet_uart_tx_pkg;

   localparam int unsigned PKT_BYTES = 22;
   localparam int unsigned PKT_WIDTH = 8 * PKT_BYTES;
   localparam int unsigned IDX_W     = $clog2(PKT_BYTES);

   localparam logic [15:0] SYNC_WORD = 16'h55AA;

   // Bit offsets of the packet fields
   localparam int unsigned PLAYER_X_OFS  = 16;
   localparam int unsigned PLAYER_Y_OFS  = 24;
   localparam int unsigned WAVE_BASE_OFS = 32;
   localparam int unsigned WAVE_STRIDE   = 48;

   // 8N1 framing
   localparam int unsigned NUM_START_BITS = 1;
   localparam int unsigned NUM_DATA_BITS  = 8;
   localparam int unsigned NUM_STOP_BITS  = 1;
   localparam int unsigned FRAME_BITS     = NUM_START_BITS + NUM_DATA_BITS + NUM_STOP_BITS;

   typedef logic [7:0] byte_t;

   // Packet layout, MSB field first; the sync word is byte 0/1 on the wire
   typedef struct packed {
      logic [2:0][47:0] wave;
      byte_t            player_y;
      byte_t            player_x;
      logic [15:0]      sync;
   } packet_t;

   // Byte-level UART line states
   typedef enum logic [1:0] {
      IDLE,
      START_BIT,
      DATA_BITS,
      STOP_BIT
   } tx_state_e;

   // Packet-level sequencing states
   typedef enum logic {
      PKT_IDLE,
      PKT_SEND
   } pkt_state_e;

   // Byte idx of a packet, byte 0 in the least-significant position
   function automatic byte_t pkt_byte(input packet_t p, input logic [IDX_W-1:0] idx);
      logic [PKT_WIDTH-1:0] v;
      v = p;
      return v[{idx, 3'b000} +: 8];
   endfunction

endpackage

// File: rtl/packet_uart_tx_if.sv
// Packet-side bus between packet assembly and the UART serializer.
interface packet_uart_tx_if;
   import packet_uart_tx_pkg::*;

   packet_t packet;
   logic    start;
   logic    busy;
   logic    done;
   logic    tx;

   modport master (output packet, output start, input busy, input done, input tx);
   modport slave  (input packet, input start, output busy, output done, output tx);

endinterface

// File: rtl/packet_uart_tx_byte.sv
// Single-byte 8N1 transmitter; ready rises in the last stop-bit cycle so a
// waiting byte starts its start bit with no idle gap.
module packet_uart_tx_byte
   import packet_uart_tx_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 868
) (
   input  logic  clk,
   input  logic  rst_n,
   input  logic  valid_i,
   input  byte_t data_i,
   output logic  ready_o,
   output logic  tx_o
);

   localparam int unsigned CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [2:0]       BIT_LAST = 3'(NUM_DATA_BITS - 1);

   tx_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       bit_q, bit_d;
   byte_t            shift_q, shift_d;
   logic             tx_q, tx_d;
   logic             ready_q, ready_d;

   // State, baud counter, bit index and registered line outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         tx_q    <= 1'b1;
         ready_q <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
         ready_q <= ready_d;
      end
   end

   // Next-state logic; line level and ready are derived from the next state
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      tx_d    = 1'b1;
      ready_d = 1'b0;

      case (state_q)
         IDLE: begin
            if (valid_i) begin
               state_d = START_BIT;
               cnt_d   = '0;
               shift_d = data_i;
            end
         end
         START_BIT: begin
            if (cnt_q == CNT_LAST) begin
               state_d = DATA_BITS;
               cnt_d   = '0;
               bit_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         DATA_BITS: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d = '0;
               if (bit_q == BIT_LAST) begin
                  state_d = STOP_BIT;
               end else begin
                  bit_d = bit_q + 3'd1;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         STOP_BIT: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d = '0;
               if (valid_i) begin
                  state_d = START_BIT;
                  shift_d = data_i;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase

      if (state_d == START_BIT) begin
         tx_d = 1'b0;
      end else if (state_d == DATA_BITS) begin
         tx_d = shift_d[bit_d];
      end

      ready_d = (state_d == IDLE) || ((state_d == STOP_BIT) && (cnt_d == CNT_LAST));
   end

   assign ready_o = ready_q;
   assign tx_o    = tx_q;

endmodule

// File: rtl/packet_uart_tx.sv
// Snapshots a game-state packet on start and streams its bytes, LSB byte
// first, back-to-back through the byte transmitter.
module packet_uart_tx
   import packet_uart_tx_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 868
) (
   input  logic         clk,
   input  logic         rst_n,
   packet_uart_tx_if.slave bus
);

   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PKT_BYTES - 1);

   pkt_state_e       state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   packet_t          shadow_q, shadow_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic             byte_valid_c;
   byte_t            byte_data_c;
   logic             byte_ready;
   logic             byte_tx;

   // Packet sequencing registers and registered status outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= PKT_IDLE;
         idx_q    <= '0;
         shadow_q <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         shadow_q <= shadow_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   // Accept a packet, then hand over the next byte each time the line frees up
   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      shadow_d     = shadow_q;
      busy_d       = busy_q;
      done_d       = 1'b0;
      byte_valid_c = 1'b0;
      byte_data_c  = '0;

      case (state_q)
         PKT_IDLE: begin
            busy_d = 1'b0;
            if (bus.start && byte_ready) begin
               // Byte 0 comes straight from the bus so the start bit is not delayed
               byte_valid_c = 1'b1;
               byte_data_c  = pkt_byte(bus.packet, '0);
               shadow_d     = bus.packet;
               idx_d        = '0;
               busy_d       = 1'b1;
               state_d      = PKT_SEND;
            end
         end
         PKT_SEND: begin
            if (byte_ready) begin
               if (idx_q == IDX_LAST) begin
                  state_d = PKT_IDLE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end else begin
                  idx_d        = idx_q + IDX_W'(1);
                  byte_valid_c = 1'b1;
                  byte_data_c  = pkt_byte(shadow_q, idx_d);
               end
            end
         end
         default: begin
            state_d = PKT_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   packet_uart_tx_byte #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_byte (
      .clk     (clk),
      .rst_n   (rst_n),
      .valid_i (byte_valid_c),
      .data_i  (byte_data_c),
      .ready_o (byte_ready),
      .tx_o    (byte_tx)
   );

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.tx   = byte_tx;

endmodule
